// File: rtl/out_sync_rd_sched.sv
// out_sync_rd_sched: credit-based FIFO read scheduler with 2-deep skid buffer and line/frame markers
// Ports: clk/rst (sync, active-high); slice_width/slice_height give the geometry (E = slice_width>>1 words per line);
// enable gates the scheduler; buf_* is the FIFO read side (buf_valid one cycle after buf_rd_en);
// out_* is the valid/ready sink side with sol/eol/sof/eof markers;
// frame_done, sof_abort are pulses; underflow_err, cfg_err are sticky.
module out_sync_rd_sched #(
  parameter int DATA_WIDTH = 4*3*14,
  parameter int MAX_SLICE_WIDTH = 2560,
  parameter int MAX_SLICE_HEIGHT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic [$clog2(MAX_SLICE_WIDTH)-1:0] slice_width,
  input  logic [$clog2(MAX_SLICE_HEIGHT)-1:0] slice_height,
  input  logic enable,
  input  logic buf_empty,
  input  logic buf_sof,
  output logic buf_rd_en,
  input  logic buf_valid,
  input  logic [DATA_WIDTH-1:0] buf_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic out_valid,
  input  logic out_ready,
  output logic out_sol,
  output logic out_eol,
  output logic out_sof,
  output logic out_eof,
  output logic frame_done,
  output logic underflow_err,
  output logic cfg_err,
  output logic sof_abort
);
  localparam int WW = $clog2(MAX_SLICE_WIDTH);
  localparam int HW = $clog2(MAX_SLICE_HEIGHT);
  localparam logic [1:0] IDLE = 2'd0, WAIT_SOF = 2'd1, RUN = 2'd2;
  logic [1:0] state, cnt;
  logic sof_q, inflight, wp, rp;
  logic [DATA_WIDTH-1:0] mem [2];
  logic [WW-1:0] e_in, e_q, rd_col, out_col;
  logic [HW-1:0] h_q, rd_row, out_row;
  logic run, sof_rise, cfg_ok, start, push, pop, col_last, rd_col_last, underflow;
  always_comb begin
    e_in = slice_width >> 1;
    run = state == RUN;
    sof_rise = buf_sof & ~sof_q;
    cfg_ok = e_in >= WW'(2) && slice_height != '0;
    start = enable & sof_rise & (run | (state == WAIT_SOF & cfg_ok));
    // rd_row reaches h_q exactly when all E*H words of the slice have been issued
    buf_rd_en = run & enable & ~sof_rise & ~buf_empty & (cnt == 2'd0 | (cnt == 2'd1 & ~inflight)) & rd_row != h_q;
    out_valid = cnt != 2'd0;
    out_data = mem[rp];
    push = buf_valid & inflight;
    pop = out_valid & out_ready;
    col_last = out_col == e_q - WW'(1);
    rd_col_last = rd_col == e_q - WW'(1);
    out_sol = out_valid & out_col == '0;
    out_eol = out_valid & col_last;
    out_sof = out_sol & out_row == '0;
    out_eof = out_eol & out_row == h_q - HW'(1);
    // RUN is left on the last accept, so being in RUN already means the frame is incomplete
    underflow = run & out_ready & ~out_valid & ~inflight & buf_empty;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sof_q <= 1'b0;
      inflight <= 1'b0;
      wp <= 1'b0;
      rp <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
      e_q <= '0;
      h_q <= '0;
      rd_col <= '0;
      rd_row <= '0;
      out_col <= '0;
      out_row <= '0;
      frame_done <= 1'b0;
      underflow_err <= 1'b0;
      cfg_err <= 1'b0;
      sof_abort <= 1'b0;
    end else begin
      sof_q <= buf_sof;
      frame_done <= 1'b0;
      sof_abort <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt <= '0;
        wp <= 1'b0;
        rp <= 1'b0;
        inflight <= 1'b0;
      end else if (start) begin
        state <= RUN;
        sof_abort <= run;
        e_q <= e_in;
        h_q <= slice_height;
        rd_col <= '0;
        rd_row <= '0;
        out_col <= '0;
        out_row <= '0;
        cnt <= '0;
        wp <= 1'b0;
        rp <= 1'b0;
        inflight <= 1'b0;
        underflow_err <= 1'b0;
      end else begin
        if (state == IDLE) state <= WAIT_SOF;
        if (state == WAIT_SOF && sof_rise) cfg_err <= 1'b1;
        if (underflow) underflow_err <= 1'b1;
        inflight <= buf_rd_en | (inflight & ~buf_valid);
        cnt <= cnt + {1'b0, push} - {1'b0, pop};
        if (push) begin
          mem[wp] <= buf_data;
          wp <= ~wp;
        end
        if (pop) rp <= ~rp;
        if (buf_rd_en) begin
          rd_col <= rd_col_last ? '0 : rd_col + WW'(1);
          rd_row <= rd_col_last ? rd_row + HW'(1) : rd_row;
        end
        if (pop) begin
          out_col <= col_last ? '0 : out_col + WW'(1);
          out_row <= col_last ? out_row + HW'(1) : out_row;
        end
        if (pop & out_eof) begin
          state <= WAIT_SOF;
          frame_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_out_sync_rd_sched.sv
// tb_out_sync_rd_sched: self-checking bench with a FIFO model and a word-index reference for markers
module tb_out_sync_rd_sched;
  localparam int DW = 4*3*14;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, buf_empty = 1'b0, buf_sof = 1'b0, buf_valid = 1'b0, out_ready = 1'b0;
  logic [11:0] slice_width = 12'd8, slice_height = 12'd2;
  logic [DW-1:0] buf_data = '0;
  logic buf_rd_en, out_valid, out_sol, out_eol, out_sof, out_eof, frame_done, underflow_err, cfg_err, sof_abort;
  logic [DW-1:0] out_data;
  out_sync_rd_sched dut (
    .clk(clk), .rst(rst), .slice_width(slice_width), .slice_height(slice_height), .enable(enable),
    .buf_empty(buf_empty), .buf_sof(buf_sof), .buf_rd_en(buf_rd_en), .buf_valid(buf_valid), .buf_data(buf_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sol(out_sol), .out_eol(out_eol),
    .out_sof(out_sof), .out_eof(out_eof), .frame_done(frame_done), .underflow_err(underflow_err),
    .cfg_err(cfg_err), .sof_abort(sof_abort)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] pend_data = '0;
  int n_chk = 0, n_pass = 0, n_acc = 0, k = 0, cur_e = 1, cur_h = 1;
  int stall_left = 0, empty_left = 0, stall_at = -1, empty_at = -1, abort_at = -1;
  bit in_frame = 0, fd_exp = 0, ab_exp = 0, uf_exp = 0, rd_pend = 0, sof_req = 0, rand_ready = 0, rand_empty = 0;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  function automatic logic [DW-1:0] rnd_word();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[DW-1:0];
  endfunction
  task automatic cyc();
    int col, row;
    logic [DW-1:0] w;
    @(posedge clk);
    #1;
    buf_valid = rd_pend;
    buf_data = rd_pend ? pend_data : rnd_word();
    buf_sof = sof_req;
    sof_req = 0;
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else out_ready = !rand_ready || $urandom_range(0, 3) != 0;
    if (empty_left > 0) begin
      buf_empty = 1'b1;
      empty_left--;
    end else buf_empty = rand_empty && $urandom_range(0, 4) == 0;
    #1;
    chk("frame_done", frame_done, fd_exp);
    chk("sof_abort", sof_abort, ab_exp);
    chk("underflow_err", underflow_err, uf_exp);
    chk("outstanding_le2", (exp_q.size() <= 2), 1);
    fd_exp = 0;
    ab_exp = 0;
    if (!in_frame || buf_sof) chk("rd_en_idle", buf_rd_en, 0);
    if (!in_frame) chk("valid_idle", out_valid, 0);
    rd_pend = 0;
    if (buf_sof) begin
      if (enable && (in_frame || ((slice_width >> 1) >= 2 && slice_height != 0))) begin
        ab_exp = in_frame;
        in_frame = 1;
        exp_q.delete();
        k = 0;
        n_acc = 0;
        uf_exp = 0;
        cur_e = int'(slice_width >> 1);
        cur_h = int'(slice_height);
      end
    end else begin
      if (in_frame && out_ready && buf_empty && exp_q.size() == 0) uf_exp = 1;
      if (out_valid && out_ready) begin
        col = k % cur_e;
        row = k / cur_e;
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("data", out_data, w);
        end else chk("spurious_word", out_valid, 0);
        chk("sol", out_sol, col == 0);
        chk("eol", out_eol, col == cur_e - 1);
        chk("sof", out_sof, col == 0 && row == 0);
        chk("eof", out_eof, col == cur_e - 1 && row == cur_h - 1);
        k++;
        n_acc++;
        if (col == cur_e - 1 && row == cur_h - 1) begin
          fd_exp = 1;
          in_frame = 0;
          k = 0;
        end
        if (in_frame && k == stall_at) begin
          stall_left = 10;
          stall_at = -1;
        end
        if (in_frame && k == empty_at) begin
          empty_left = 6;
          empty_at = -1;
        end
        if (in_frame && k == abort_at) begin
          sof_req = 1;
          abort_at = -1;
        end
      end
      if (buf_rd_en) begin
        pend_data = rnd_word();
        exp_q.push_back(pend_data);
        rd_pend = 1;
      end
    end
  endtask
  task automatic run_frame(input int w, input int h);
    int t;
    t = 0;
    slice_width = 12'(w);
    slice_height = 12'(h);
    sof_req = 1;
    while (t < 3000 && !fd_exp) begin
      cyc();
      t++;
    end
    chk("frame_timeout", fd_exp, 1);
    chk("word_count", n_acc, (w / 2) * h);
    cyc();
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_rd_en", buf_rd_en, 0);
    chk("rst_markers", {out_sol, out_eol, out_sof, out_eof}, 0);
    chk("rst_flags", {frame_done, underflow_err, cfg_err, sof_abort}, 0);
    repeat (4) cyc();
    enable = 1'b1;
    repeat (2) cyc();
    run_frame(8, 2);
    cyc();
    stall_at = 2;
    run_frame(8, 2);
    empty_at = 1;
    run_frame(8, 2);
    chk("uf_set", underflow_err, 1);
    repeat (3) cyc();
    chk("uf_sticky", underflow_err, 1);
    run_frame(8, 2);
    chk("uf_cleared", underflow_err, 0);
    abort_at = 3;
    run_frame(8, 2);
    rand_ready = 1;
    rand_empty = 1;
    repeat (6) begin
      run_frame(2 * int'($urandom_range(2, 5)), int'($urandom_range(1, 3)));
      cyc();
    end
    rand_ready = 0;
    rand_empty = 0;
    chk("cfg_clean", cfg_err, 0);
    slice_width = 12'd2;
    slice_height = 12'd2;
    sof_req = 1;
    repeat (2) cyc();
    chk("cfg_err_set", cfg_err, 1);
    repeat (5) cyc();
    chk("cfg_err_sticky", cfg_err, 1);
    chk("cfg_no_read", buf_rd_en, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
